// File: rtl/lanes_mosi_dispatch.sv
// rtl/lanes_mosi_dispatch.sv - routes LEN-framed host command packets to per-lane MOSI streams.
// Optional LANES_MOSI_BROADCAST_EN: header ID 0xF fans the payload out to every lane.
module lanes_mosi_dispatch #(
  parameter int LANE_COUNT = 3
) (
  input  logic                      clk_core,
  input  logic                      clk_core_rst,
  input  logic [7:0]                cmd_s_axis_tdata,
  input  logic                      cmd_s_axis_tvalid,
  output logic                      cmd_s_axis_tready,
  output logic [LANE_COUNT*8-1:0]   lanes_mosi_m_axis_tdata,
  output logic [LANE_COUNT-1:0]     lanes_mosi_m_axis_tvalid,
  output logic [LANE_COUNT-1:0]     lanes_mosi_m_axis_tlast,
  input  logic [LANE_COUNT-1:0]     lanes_mosi_m_axis_tready,
  output logic                      status_busy,
  output logic [3:0]                status_lane,
  output logic [15:0]               stat_packet_count,
  output logic [15:0]               stat_drop_count
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              lane_id;
  logic [7:0]              len_hi;
  logic [15:0]             count;
  logic [LANE_COUNT-1:0]   pend;
  logic [7:0]              out_data;
  logic                    out_last;

  logic [LANE_COUNT-1:0]   pend_left;
  logic                    accept;
  logic [15:0]             len_full;
  logic                    id_ok;
  logic [LANE_COUNT-1:0]   lane_mask;

  // Bits still waiting after this cycle's lane handshakes
  assign pend_left = pend & ~lanes_mosi_m_axis_tready;
  assign accept    = cmd_s_axis_tvalid & cmd_s_axis_tready;
  assign len_full  = {len_hi, cmd_s_axis_tdata};

  always_comb begin
    id_ok     = (lane_id != 4'd0) && (32'(lane_id) <= LANE_COUNT);
    lane_mask = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (32'(lane_id) == i + 1) lane_mask[i] = 1'b1;
    end
`ifdef LANES_MOSI_BROADCAST_EN
    if (lane_id == 4'hF) begin
      id_ok     = 1'b1;
      lane_mask = '1;
    end
`endif
  end

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) state <= S_HDR;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:     if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0) state_nxt = S_HDR;
          else if (id_ok)        state_nxt = S_PAYLOAD;
          else                   state_nxt = S_DROP;
        end
      end
      S_PAYLOAD: if (accept && count == 16'd1) state_nxt = S_HDR;
      S_DROP:    if (accept && count == 16'd1) state_nxt = S_HDR;
      default:   state_nxt = S_HDR;
    endcase
  end

  // Payload input waits until the held byte is (or is about to be) fully taken
  always_comb begin
    cmd_s_axis_tready = (state != S_PAYLOAD) || (pend_left == '0);
    status_busy       = (state != S_HDR) || (pend != '0);
  end

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      lane_id           <= 4'd0;
      len_hi            <= 8'd0;
      count             <= 16'd0;
      pend              <= '0;
      out_data          <= 8'd0;
      out_last          <= 1'b0;
      status_lane       <= 4'd0;
      stat_packet_count <= 16'd0;
      stat_drop_count   <= 16'd0;
    end else begin
      pend <= pend_left;
      if (accept) begin
        case (state)
          S_HDR:    lane_id <= cmd_s_axis_tdata[7:4];
          S_LEN_HI: len_hi  <= cmd_s_axis_tdata;
          S_LEN_LO: begin
            count       <= len_full;
            status_lane <= lane_id;
            if (len_full != 16'd0) begin
              if (id_ok)                           stat_packet_count <= stat_packet_count + 16'd1;
              else if (stat_drop_count != 16'hFFFF) stat_drop_count   <= stat_drop_count + 16'd1;
            end
          end
          S_PAYLOAD: begin
            pend     <= lane_mask;
            out_data <= cmd_s_axis_tdata;
            out_last <= (count == 16'd1);
            count    <= count - 16'd1;
          end
          S_DROP:   count <= count - 16'd1;
          default:  ;
        endcase
      end
    end
  end

  assign lanes_mosi_m_axis_tvalid = pend;
  assign lanes_mosi_m_axis_tlast  = pend & {LANE_COUNT{out_last}};
  assign lanes_mosi_m_axis_tdata  = {LANE_COUNT{out_data}};

endmodule

// File: tb/tb_lanes_mosi_dispatch.sv
// tb/tb_lanes_mosi_dispatch.sv - table vectors, hand sequences and random packets against a packet-level model.
module tb_lanes_mosi_dispatch;
  localparam int LC = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       cmd_tdata;
  logic             cmd_tvalid;
  logic             cmd_tready;
  logic [LC*8-1:0]  l_tdata;
  logic [LC-1:0]    l_tvalid;
  logic [LC-1:0]    l_tlast;
  logic [LC-1:0]    l_tready;
  logic             busy;
  logic [3:0]       slane;
  logic [15:0]      pkt_cnt;
  logic [15:0]      drop_cnt;

  always #5 clk = ~clk;

  lanes_mosi_dispatch #(.LANE_COUNT(LC)) dut (
    .clk_core                 (clk),
    .clk_core_rst             (rst),
    .cmd_s_axis_tdata         (cmd_tdata),
    .cmd_s_axis_tvalid        (cmd_tvalid),
    .cmd_s_axis_tready        (cmd_tready),
    .lanes_mosi_m_axis_tdata  (l_tdata),
    .lanes_mosi_m_axis_tvalid (l_tvalid),
    .lanes_mosi_m_axis_tlast  (l_tlast),
    .lanes_mosi_m_axis_tready (l_tready),
    .status_busy              (busy),
    .status_lane              (slane),
    .stat_packet_count        (pkt_cnt),
    .stat_drop_count          (drop_cnt)
  );

  typedef struct {
    logic [7:0]       hdr;
    int               len;
    logic [31:0]      pl;      // pl[7:0] is the first payload byte
    int               rmode;
    int               lane;    // -1 none, 0..LC-1 one lane, LC all lanes
    int               dpkt;
    int               ddrop;
    bit               consec;
  } vec_t;

  vec_t        vecs[9];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  in_q[$];
  logic [7:0]  stream[$];
  int          rxq[LC][$];     // {cycle, last, data}
  int          expq[LC][$];    // {last, data}
  int          rmode[LC];
  int          vcnt[LC];
  int          valid_gaps = 0;
  int          cyc = 0;
  int          accepted = 0;
  int          exp_pkt, exp_drop;
  int          pp = 0, cur_rem = 0;
  logic [3:0]  cur_id;
  logic [7:0]  cur_lh;
  bit          cur_fwd = 0;
  logic [LC-1:0] prev_unacc = '0;
  logic [7:0]  prev_data[LC];
  logic        prev_last[LC];

  function automatic bit id_ok(input int id);
`ifdef LANES_MOSI_BROADCAST_EN
    if (id == 15) return 1'b1;
`endif
    return (id >= 1) && (id <= LC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_q.push_back(b);
    stream.push_back(b);
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input int len, input logic [31:0] pl);
    logic [15:0] l16;
    l16 = 16'(len);
    push_byte(hdr);
    push_byte(l16[15:8]);
    push_byte(l16[7:0]);
    for (int k = 0; k < len; k++) push_byte(pl[(k % 4) * 8 +: 8] ^ 8'(k / 4));
  endtask

  task automatic clear_all();
    in_q.delete();
    stream.delete();
    for (int i = 0; i < LC; i++) begin
      rxq[i].delete();
      expq[i].delete();
      vcnt[i] = 0;
    end
  endtask

  // Packet-level reference: walks the byte stream by header/length and lists what each lane must see.
  task automatic model();
    int i;
    logic [7:0] h;
    int id, len;
    exp_pkt = 0;
    exp_drop = 0;
    for (int l = 0; l < LC; l++) expq[l].delete();
    i = 0;
    while (i + 2 < stream.size()) begin
      h   = stream[i];
      id  = int'(h[7:4]);
      len = int'({stream[i+1], stream[i+2]});
      i += 3;
      if (len != 0) begin
        if (id_ok(id)) begin
          exp_pkt++;
          for (int k = 0; k < len; k++) begin
            for (int l = 0; l < LC; l++)
              if (id == 15 || id == l + 1)
                expq[l].push_back(((k == len - 1) ? 256 : 0) | int'(stream[i+k]));
          end
        end else exp_drop++;
        i += len;
      end
    end
  endtask

  task automatic drive();
    if (!(cmd_tvalid && in_q.size() > 0))
      cmd_tvalid = (in_q.size() > 0) && (valid_gaps == 0 || $urandom_range(0, 3) != 0);
    cmd_tdata = (in_q.size() > 0) ? in_q[0] : 8'h00;
    for (int i = 0; i < LC; i++) begin
      case (rmode[i])
        0:       l_tready[i] = 1'b1;
        1:       l_tready[i] = (cyc % 2 == 0);
        2:       l_tready[i] = 1'($urandom_range(0, 1));
        default: l_tready[i] = (vcnt[i] >= 3);
      endcase
    end
  endtask

  task automatic sample();
    logic [7:0] b;
    for (int i = 0; i < LC; i++) begin
      if (prev_unacc[i]) begin
        chk($sformatf("hold_valid_l%0d", i), 32'(l_tvalid[i]), 32'd1);
        chk($sformatf("hold_data_l%0d", i), 32'(l_tdata[i*8 +: 8]), 32'(prev_data[i]));
        chk($sformatf("hold_last_l%0d", i), 32'(l_tlast[i]), 32'(prev_last[i]));
      end
    end
    chk("last_without_valid", 32'(l_tlast & ~l_tvalid), 32'd0);
    if (pp == 3 && cur_fwd)
      chk("payload_cmd_tready", 32'(cmd_tready), 32'((l_tvalid & ~l_tready) == '0));
    for (int i = 0; i < LC; i++) begin
      if (l_tvalid[i] && l_tready[i]) begin
        rxq[i].push_back((cyc << 9) | (l_tlast[i] ? 256 : 0) | int'(l_tdata[i*8 +: 8]));
        vcnt[i] = 0;
      end else if (l_tvalid[i]) vcnt[i]++;
      prev_data[i] = l_tdata[i*8 +: 8];
      prev_last[i] = l_tlast[i];
    end
    prev_unacc = l_tvalid & ~l_tready;
    if (cmd_tvalid && cmd_tready) begin
      b = in_q.pop_front();
      accepted++;
      case (pp)
        0: begin cur_id = b[7:4]; pp = 1; end
        1: begin cur_lh = b; pp = 2; end
        2: begin
          cur_rem = int'({cur_lh, b});
          if (cur_rem == 0) pp = 0;
          else begin pp = 3; cur_fwd = id_ok(int'(cur_id)); end
        end
        default: begin cur_rem--; if (cur_rem == 0) pp = 0; end
      endcase
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int stop_acc);
    int n;
    n = 0;
    forever begin
      if (stop_acc > 0 && accepted >= stop_acc) break;
      if (stop_acc == 0 && in_q.size() == 0 && !busy) break;
      if (n >= 3000) begin
        checks++;
        failures++;
        $display("FAIL run_timeout actual=%0d cycles required=done", n);
        break;
      end
      cycle();
      n++;
    end
    cmd_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_tvalid = 1'b0;
    l_tready = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pp = 0;
    prev_unacc = '0;
    accepted = 0;
    clear_all();
  endtask

  task automatic compare_lanes(input string tag);
    bit ok;
    for (int i = 0; i < LC; i++) begin
      ok = (rxq[i].size() == expq[i].size());
      if (ok) for (int k = 0; k < rxq[i].size(); k++) ok &= ((rxq[i][k] & 32'h1FF) == expq[i][k]);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s_lane%0d actual=%0d bytes first=%0h required=%0d bytes first=%0h", tag, i,
                 rxq[i].size(), (rxq[i].size() > 0) ? (rxq[i][0] & 32'h1FF) : 0,
                 expq[i].size(), (expq[i].size() > 0) ? expq[i][0] : 0);
      end
    end
  endtask

  task automatic setv(input int idx, input logic [7:0] hdr, input int len, input logic [31:0] pl,
                      input int rm, input int lane, input int dpkt, input int ddrop, input bit consec);
    vecs[idx].hdr = hdr;  vecs[idx].len = len;   vecs[idx].pl = pl;
    vecs[idx].rmode = rm; vecs[idx].lane = lane; vecs[idx].dpkt = dpkt;
    vecs[idx].ddrop = ddrop; vecs[idx].consec = consec;
  endtask

  initial begin
    logic [15:0] p0, d0;
    int t0, t1;
    int n_pk, len, id;
    logic [7:0] hdr;

    setv(0, 8'h20, 3, 32'h00A3A2A1, 0, 1, 1, 0, 1);
    setv(1, 8'h20, 3, 32'h00A3A2A1, 1, 1, 1, 0, 0);
    setv(2, 8'h50, 2, 32'h0000B2B1, 0, -1, 0, 1, 0);
    setv(3, 8'h10, 1, 32'h000000C1, 0, 0, 1, 0, 0);
    setv(4, 8'h1A, 0, 32'h00000000, 0, -1, 0, 0, 0);
    setv(5, 8'h30, 1, 32'h000000D1, 2, 2, 1, 0, 0);
    setv(6, 8'h05, 2, 32'h00005A5B, 0, -1, 0, 1, 0);
`ifdef LANES_MOSI_BROADCAST_EN
    setv(7, 8'hF3, 1, 32'h0000007E, 2, LC, 1, 0, 0);
`else
    setv(7, 8'hF3, 1, 32'h0000007E, 2, -1, 0, 1, 0);
`endif
    setv(8, 8'h4F, 1, 32'h00000099, 0, -1, 0, 1, 0);

    rst = 1'b1;
    cmd_tvalid = 1'b0;
    cmd_tdata = 8'h00;
    l_tready = '0;
    for (int i = 0; i < LC; i++) begin rmode[i] = 0; prev_data[i] = 8'h00; prev_last[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(l_tvalid), 32'd0);
    chk("rst_tlast", 32'(l_tlast), 32'd0);
    chk("rst_tdata", 32'(l_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_tready", 32'(cmd_tready), 32'd1);
    chk("rst_counts", {pkt_cnt, drop_cnt}, 32'd0);
    chk("rst_status_lane", 32'(slane), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      clear_all();
      p0 = pkt_cnt;
      d0 = drop_cnt;
      valid_gaps = 0;
      for (int i = 0; i < LC; i++) rmode[i] = vecs[v].rmode;
      push_pkt(vecs[v].hdr, vecs[v].len, vecs[v].pl);
      for (int i = 0; i < LC; i++)
        if (vecs[v].lane == i || vecs[v].lane == LC)
          for (int k = 0; k < vecs[v].len; k++)
            expq[i].push_back(((k == vecs[v].len - 1) ? 256 : 0) | int'(vecs[v].pl[k*8 +: 8]));
      run(0);
      compare_lanes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_pkt_delta", v), 32'(16'(pkt_cnt - p0)), 32'(vecs[v].dpkt));
      chk($sformatf("vec%0d_drop_delta", v), 32'(16'(drop_cnt - d0)), 32'(vecs[v].ddrop));
      chk($sformatf("vec%0d_status_lane", v), 32'(slane), 32'(vecs[v].hdr[7:4]));
      if (vecs[v].consec && vecs[v].lane >= 0 && vecs[v].lane < LC)
        for (int k = 1; k < rxq[vecs[v].lane].size(); k++)
          chk($sformatf("vec%0d_consec%0d", v, k), 32'(rxq[vecs[v].lane][k] >>> 9),
              32'((rxq[vecs[v].lane][0] >>> 9) + k));
    end

    // Reset after the second of four payload bytes, then a clean lane-2 packet
    clear_all();
    for (int i = 0; i < LC; i++) rmode[i] = 0;
    push_pkt(8'h20, 4, 32'h44332211);
    accepted = 0;
    run(5);
    do_reset();
    chk("midrst_tvalid", 32'(l_tvalid), 32'd0);
    chk("midrst_counts", {pkt_cnt, drop_cnt}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_tready", 32'(cmd_tready), 32'd1);
    push_pkt(8'h20, 2, 32'h0000F2F1);
    model();
    run(0);
    compare_lanes("after_rst");
    chk("after_rst_pkt", 32'(pkt_cnt), 32'd1);

`ifdef LANES_MOSI_BROADCAST_EN
    clear_all();
    rmode[0] = 0; rmode[1] = 0; rmode[2] = 3;
    push_pkt(8'hF0, 2, 32'h0000E2E1);
    model();
    run(0);
    compare_lanes("bcast");
    chk("bcast_status_lane", 32'(slane), 32'hF);
    if (rxq[2].size() > 0 && rxq[0].size() > 1) begin
      t0 = rxq[2][0] >>> 9;
      t1 = rxq[0][1] >>> 9;
      chk("bcast_e2_after_lane2_e1", 32'(t1 > t0), 32'd1);
    end
`endif

    // Random packet mixes with random valid gaps and lane backpressure
    for (int it = 0; it < 30; it++) begin
      clear_all();
      p0 = pkt_cnt;
      d0 = drop_cnt;
      valid_gaps = 1;
      for (int i = 0; i < LC; i++) rmode[i] = (it % 5 == 4) ? 1 : 2;
      n_pk = $urandom_range(1, 4);
      for (int p = 0; p < n_pk; p++) begin
        id  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, LC);
        len = (it == 7 && p == 0) ? 300 : $urandom_range(0, 5);
        hdr = {4'(id), 4'($urandom_range(0, 15))};
        push_pkt(hdr, len, $urandom);
      end
      model();
      run(0);
      compare_lanes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_pkt_delta", it), 32'(16'(pkt_cnt - p0)), 32'(exp_pkt));
      chk($sformatf("rnd%0d_drop_delta", it), 32'(16'(drop_cnt - d0)), 32'(exp_drop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
